sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's single-clock FIFO. It adds configurable width and depth (non-power-of-two allowed), programmable almost-full/almost-empty levels, a standard-vs-first-word-fall-through read mode, an occupancy count and a synchronous flush. It is the buffering primitive that the team's datapath blocks instantiate, and the DUT for the next round of the constrained-random FIFO bench.

---
 rtl/shared_pkg.sv | 13 +
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types and default constants for the team's buffering primitives.
package shared_pkg;

  // Read-side presentation mode of the FIFO output stage
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 8;

endpackage : shared_pkg

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately unreset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read of the addressed entry
  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable levels, STD/FWFT read mode and flush.
module sync_fifo_param
  import shared_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] rd_data;

  // Status flags straight from the registered occupancy
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL));
  assign almostempty = (count_q <= CW'(AE_LEVEL));
  assign count       = count_q;

  // Flush suppresses both ports so nothing lands in memory during a clear
  assign wr_accept = wr_en && !full  && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Next-state for pointers, occupancy and handshake pulses
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ack_d    = wr_accept;
      overflow_d  = wr_en && !wr_accept;
      underflow_d = rd_en && !rd_accept;
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head word is presented as soon as it exists; zero while empty
    assign data_out   = empty ? '0 : rd_data;
    assign data_valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    // Capture the head word only on an accepted pop; hold otherwise
    always_comb begin
      data_out_d   = data_out_q;
      data_valid_d = rd_accept;
      if (rd_accept) begin
        data_out_d = rd_data;
      end
    end

    // Registered read output stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else begin
        data_out_q   <= data_out_d;
        data_valid_q <= data_valid_d;
      end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
  end

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO driven by the same stimulus.
module tb_sync_fifo_param;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_en, rd_en;
  logic [W-1:0]  data_in;

  logic [W-1:0]  s_data_out, f_data_out;
  logic          s_data_valid, f_data_valid;
  logic          s_wr_ack, f_wr_ack, s_overflow, f_overflow, s_underflow, f_underflow;
  logic          s_full, f_full, s_empty, f_empty, s_af, f_af, s_ae, f_ae;
  logic [CW-1:0] s_count, f_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(s_data_out), .data_valid(s_data_valid),
    .wr_ack(s_wr_ack), .overflow(s_overflow), .underflow(s_underflow),
    .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae),
    .count(s_count)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(f_data_out), .data_valid(f_data_valid),
    .wr_ack(f_wr_ack), .overflow(f_overflow), .underflow(f_underflow),
    .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
    .count(f_count)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); data_in = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (s_count !== CW'(0)) begin n_err++; $display("FAIL reset_count got %0d exp 0", s_count); end
    n_cmp++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin n_err++; $display("FAIL reset_flags got %b exp 1100", {s_empty, s_ae, s_full, s_af}); end
    n_cmp++; if ({s_wr_ack, s_overflow, s_underflow, s_data_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses got %b exp 0000", {s_wr_ack, s_overflow, s_underflow, s_data_valid}); end
    n_cmp++; if (s_data_out !== 16'h0000) begin n_err++; $display("FAIL reset_dout got %h exp 0000", s_data_out); end
    n_cmp++; if ({f_data_valid, f_data_out} !== 17'h0) begin n_err++; $display("FAIL reset_fwft got %b/%h exp 0/0000", f_data_valid, f_data_out); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = W'(i);
      tick();
      n_cmp++; if (s_wr_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack[%0d] got %b exp 1", i, s_wr_ack); end
      n_cmp++; if (s_count !== CW'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_count, i); end
      n_cmp++; if (s_af !== (i >= 7)) begin n_err++; $display("FAIL fill_af[%0d] got %b exp %b", i, s_af, (i >= 7)); end
      n_cmp++; if (s_full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, s_full, (i == 8)); end
    end
    data_in = 16'h0009;
    tick();
    n_cmp++; if ({s_overflow, s_wr_ack} !== 2'b10) begin n_err++; $display("FAIL fill_ovf got ovf/ack %b exp 10", {s_overflow, s_wr_ack}); end
    n_cmp++; if (s_count !== CW'(8)) begin n_err++; $display("FAIL fill_ovf_count got %0d exp 8", s_count); end
    idle();
  endtask

  task automatic test_drain();
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++; if (s_data_out !== W'(i) || s_data_valid !== 1'b1) begin n_err++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", i, s_data_out, s_data_valid, i); end
      n_cmp++; if (s_count !== CW'(8 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, s_count, 8 - i); end
    end
    n_cmp++; if ({s_empty, s_ae} !== 2'b11) begin n_err++; $display("FAIL drain_empty got %b exp 11", {s_empty, s_ae}); end
    tick();
    n_cmp++; if (s_underflow !== 1'b1) begin n_err++; $display("FAIL drain_udf got %b exp 1", s_underflow); end
    n_cmp++; if (s_data_out !== 16'h0008 || s_data_valid !== 1'b0) begin n_err++; $display("FAIL drain_hold got %h/%b exp 0008/0", s_data_out, s_data_valid); end
    idle();
    tick();
    n_cmp++; if (s_underflow !== 1'b0) begin n_err++; $display("FAIL udf_pulse got %b exp 0", s_underflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = W'(16'h0010 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00EE;
    tick();
    n_cmp++; if ({s_overflow, s_wr_ack} !== 2'b10) begin n_err++; $display("FAIL full_both_ovf got %b exp 10", {s_overflow, s_wr_ack}); end
    n_cmp++; if (s_count !== CW'(7)) begin n_err++; $display("FAIL full_both_count got %0d exp 7", s_count); end
    n_cmp++; if (s_data_out !== 16'h0011) begin n_err++; $display("FAIL full_both_data got %h exp 0011", s_data_out); end
    idle(); flush = 1'b1;
    tick();
    n_cmp++; if (s_count !== CW'(0)) begin n_err++; $display("FAIL flush_to_empty got %0d exp 0", s_count); end
    flush = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
    tick();
    n_cmp++; if ({s_underflow, s_wr_ack} !== 2'b11) begin n_err++; $display("FAIL empty_both got udf/ack %b exp 11", {s_underflow, s_wr_ack}); end
    n_cmp++; if (s_count !== CW'(1)) begin n_err++; $display("FAIL empty_both_count got %0d exp 1", s_count); end
    wr_en = 1'b0;
    tick();
    n_cmp++; if (s_data_out !== 16'h0055 || s_count !== CW'(0)) begin n_err++; $display("FAIL empty_both_read got %h/%0d exp 0055/0", s_data_out, s_count); end
    idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = (i >= 2); data_in = W'(16'h0100 + i);
      tick();
      if (i >= 2) begin
        n_cmp++; if (s_data_out !== W'(16'h0100 + i - 2) || s_data_valid !== 1'b1) begin n_err++; $display("FAIL wrap_data[%0d] got %h/%b exp %h/1", i, s_data_out, s_data_valid, 16'h0100 + i - 2); end
      end
      n_cmp++; if (s_count !== CW'((i >= 1) ? 2 : 1)) begin n_err++; $display("FAIL wrap_count[%0d] got %0d", i, s_count); end
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int j = 18; j < 20; j++) begin
      tick();
      n_cmp++; if (s_data_out !== W'(16'h0100 + j)) begin n_err++; $display("FAIL wrap_tail[%0d] got %h exp %h", j, s_data_out, 16'h0100 + j); end
    end
    n_cmp++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b exp 1", s_empty); end
    idle();
  endtask

  task automatic test_fwft();
    wr_en = 1'b1; data_in = 16'hABCD;
    tick();
    n_cmp++; if (f_data_out !== 16'hABCD || f_data_valid !== 1'b1) begin n_err++; $display("FAIL fwft_head got %h/%b exp abcd/1", f_data_out, f_data_valid); end
    n_cmp++; if (f_count !== CW'(1)) begin n_err++; $display("FAIL fwft_count got %0d exp 1", f_count); end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    n_cmp++; if (f_empty !== 1'b1 || f_data_valid !== 1'b0) begin n_err++; $display("FAIL fwft_pop got empty/valid %b/%b exp 1/0", f_empty, f_data_valid); end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = W'(16'h0200 + i);
      tick();
    end
    n_cmp++; if (s_count !== CW'(5)) begin n_err++; $display("FAIL flush_pre got %0d exp 5", s_count); end
    flush = 1'b1; wr_en = 1'b1; data_in = 16'h02FF;
    tick();
    n_cmp++; if (s_count !== CW'(0) || s_empty !== 1'b1) begin n_err++; $display("FAIL flush_count got %0d/%b exp 0/1", s_count, s_empty); end
    n_cmp++; if ({s_wr_ack, s_overflow, s_data_valid} !== 3'b000) begin n_err++; $display("FAIL flush_pulses got %b exp 000", {s_wr_ack, s_overflow, s_data_valid}); end
    n_cmp++; if (s_data_out !== 16'hABCD) begin n_err++; $display("FAIL flush_hold got %h exp abcd", s_data_out); end
    flush = 1'b0; data_in = 16'h0300;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    n_cmp++; if (s_data_out !== 16'h0300) begin n_err++; $display("FAIL flush_after got %h exp 0300", s_data_out); end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = W'(16'h0400 + i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (s_count !== CW'(0) || s_empty !== 1'b1 || s_ae !== 1'b1) begin n_err++; $display("FAIL midrst_state got %0d/%b/%b exp 0/1/1", s_count, s_empty, s_ae); end
    n_cmp++; if ({s_wr_ack, s_data_valid, s_data_out} !== 18'h0) begin n_err++; $display("FAIL midrst_out got %b/%b/%h exp 0/0/0000", s_wr_ack, s_data_valid, s_data_out); end
    n_cmp++; if ({f_data_valid, f_data_out} !== 17'h0) begin n_err++; $display("FAIL midrst_fwft got %b/%h exp 0/0000", f_data_valid, f_data_out); end
    idle();
    #1 rst_n = 1'b1;
    wr_en = 1'b1; data_in = 16'h0777;
    tick();
    n_cmp++; if (s_wr_ack !== 1'b1 || s_count !== CW'(1)) begin n_err++; $display("FAIL postrst_write got %b/%0d exp 1/1", s_wr_ack, s_count); end
    n_cmp++; if (f_data_out !== 16'h0777) begin n_err++; $display("FAIL postrst_fwft got %h exp 0777", f_data_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_fifo_param
